// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: load opcodes, bus widths
// and the bit offsets of every field on the EXE->MEM and MEM->WB buses.
package mem_stage_pkg;

  localparam int EXE2MEM_W = 107;
  localparam int MEM2WB_W  = 102;
  localparam int MEM_WR_W  = 39;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } ld_op_e;

  localparam int IN_INST_LSB  = 0;
  localparam int IN_PC_LSB    = 32;
  localparam int IN_DEST_LSB  = 64;
  localparam int IN_GR_WE     = 69;
  localparam int IN_LD_OP_LSB = 70;
  localparam int IN_RES_MEM   = 73;
  localparam int IN_REQ       = 74;
  localparam int IN_ALU_LSB   = 75;

  localparam int OUT_INST_LSB = 0;
  localparam int OUT_PC_LSB   = 32;
  localparam int OUT_RES_LSB  = 64;
  localparam int OUT_DEST_LSB = 96;
  localparam int OUT_GR_WE    = 101;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load-data alignment: picks the byte/halfword lane from the low address bits
// and sign- or zero-extends it; unknown opcodes behave as a full-word load.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr,
  input  logic [31:0] raw,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'b00:   byte_sel = raw[7:0];
      2'b01:   byte_sel = raw[15:8];
      2'b10:   byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = addr[1] ? raw[31:16] : raw[15:0];

    case (ld_op)
      LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
      LD_BU:   load_data = {24'h0, byte_sel};
      LD_HU:   load_data = {16'h0, half_sel};
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for its data-SRAM
// response if a request was issued, and hands the aligned result to write-back.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BUS_IN_W  = EXE2MEM_W,
  parameter int BUS_OUT_W = MEM2WB_W,
  parameter int WR_BUS_W  = MEM_WR_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 EXE_to_MEM_valid,
  output logic                 MEM_allow_in,
  input  logic [BUS_IN_W-1:0]  EXE_to_MEM_bus,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  output logic                 MEM_to_WB_valid,
  input  logic                 WB_allow_in,
  output logic [BUS_OUT_W-1:0] MEM_to_WB_bus,
  output logic [WR_BUS_W-1:0]  MEM_wr_bus
);

  logic                mem_valid_q, mem_valid_d;
  logic                wait_resp_q, wait_resp_d;
  logic                buf_valid_q, buf_valid_d;
  logic [31:0]         rdata_buf_q, rdata_buf_d;
  logic [BUS_IN_W-1:0] bus_q, bus_d;

  logic        ready_go, leave, capture;
  logic [31:0] alu_result, pc, inst, raw, load_data, final_result;
  logic [2:0]  ld_op;
  logic [4:0]  dest;
  logic        res_from_mem, gr_we, load_pending;

  assign alu_result   = bus_q[IN_ALU_LSB +: 32];
  assign res_from_mem = bus_q[IN_RES_MEM];
  assign ld_op        = bus_q[IN_LD_OP_LSB +: 3];
  assign gr_we        = bus_q[IN_GR_WE];
  assign dest         = bus_q[IN_DEST_LSB +: 5];
  assign pc           = bus_q[IN_PC_LSB +: 32];
  assign inst         = bus_q[IN_INST_LSB +: 32];

  // A buffered response wins over the live bus, which may already carry the next reply.
  assign ready_go = ~wait_resp_q | data_sram_data_ok | buf_valid_q;
  assign leave    = ready_go & WB_allow_in;
  assign capture  = EXE_to_MEM_valid & MEM_allow_in;
  assign raw      = buf_valid_q ? rdata_buf_q : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .ld_op     (ld_op),
    .addr      (alu_result[1:0]),
    .raw       (raw),
    .load_data (load_data)
  );

  assign final_result = res_from_mem ? load_data : alu_result;
  assign load_pending = mem_valid_q & res_from_mem & ~ready_go;

  assign MEM_allow_in    = ~mem_valid_q | leave;
  assign MEM_to_WB_valid = mem_valid_q & ready_go;
  assign MEM_to_WB_bus   = {gr_we, dest, final_result, pc, inst};
  assign MEM_wr_bus      = {gr_we & mem_valid_q, dest, final_result, load_pending};

  always_comb begin
    mem_valid_d = mem_valid_q;
    wait_resp_d = wait_resp_q;
    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;
    bus_d       = bus_q;

    if (MEM_allow_in) begin
      mem_valid_d = EXE_to_MEM_valid;
      wait_resp_d = capture & EXE_to_MEM_bus[IN_REQ];
    end
    if (capture) bus_d = EXE_to_MEM_bus;

    // Response arrived but write-back is blocked: park it until the stage drains.
    if (leave) begin
      buf_valid_d = 1'b0;
    end else if (data_sram_data_ok & wait_resp_q) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
      wait_resp_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      wait_resp_q <= 1'b0;
      buf_valid_q <= 1'b0;
      rdata_buf_q <= '0;
      bus_q       <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      wait_resp_q <= wait_resp_d;
      buf_valid_q <= buf_valid_d;
      rdata_buf_q <= rdata_buf_d;
      bus_q       <= bus_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, hand-written corner sequences
// and a randomized run, all scored against a transaction-level model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         EXE_to_MEM_valid;
  logic         MEM_allow_in;
  logic [106:0] EXE_to_MEM_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         MEM_to_WB_valid;
  logic         WB_allow_in;
  logic [101:0] MEM_to_WB_bus;
  logic [38:0]  MEM_wr_bus;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .EXE_to_MEM_valid  (EXE_to_MEM_valid),
    .MEM_allow_in      (MEM_allow_in),
    .EXE_to_MEM_bus    (EXE_to_MEM_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .WB_allow_in       (WB_allow_in),
    .MEM_to_WB_bus     (MEM_to_WB_bus),
    .MEM_wr_bus        (MEM_wr_bus)
  );

  typedef struct {
    logic [31:0] alu;
    bit          req;
    bit          rfm;
    logic [2:0]  op;
    bit          we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
  } instr_t;

  typedef struct {
    logic [2:0]  op;
    bit          rfm;
    bit          req;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  // Model: the instruction occupying the stage and the state of its response.
  instr_t      m_ins;
  bit          m_valid, m_wait, m_has;
  logic [31:0] m_data;

  bit          c_ev, c_dok, c_wba;
  logic [106:0] c_bus;
  logic [31:0] c_rd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [106:0] mk_bus(input logic [31:0] alu, input bit req, input bit rfm,
                                          input logic [2:0] op, input bit we, input logic [4:0] dest,
                                          input logic [31:0] pc, input logic [31:0] inst);
    return {alu, req, rfm, op, we, dest, pc, inst};
  endfunction

  function automatic instr_t unpack(input logic [106:0] b);
    instr_t i;
    i.alu  = b[106:75];
    i.req  = b[74];
    i.rfm  = b[73];
    i.op   = b[72:70];
    i.we   = b[69];
    i.dest = b[68:64];
    i.pc   = b[63:32];
    i.inst = b[31:0];
    return i;
  endfunction

  // Loads computed arithmetically: shift the lane down, mask, extend by adding the high fill.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] raw);
    int unsigned ai = a;
    int unsigned b = (raw >> (8 * ai)) & 32'hFF;
    int unsigned h = (raw >> (16 * (ai / 2))) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return raw;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wait = 0; m_has = 0; m_data = '0;
    m_ins = unpack('0);
  endtask

  task automatic drive(input bit ev, input logic [106:0] bus, input bit dok,
                       input logic [31:0] rd, input bit wba);
    bit          done;
    logic [31:0] fin;
    @(negedge clk);
    c_ev = ev; c_bus = bus; c_dok = dok; c_rd = rd; c_wba = wba;
    EXE_to_MEM_valid = ev; EXE_to_MEM_bus = bus;
    data_sram_data_ok = dok; data_sram_rdata = rd; WB_allow_in = wba;
    #1;
    done = !m_wait || dok || m_has;
    chk("allow_in", MEM_allow_in, !m_valid || (done && wba));
    chk("wb_valid", MEM_to_WB_valid, m_valid && done);
    chk("load_pending", MEM_wr_bus[0], m_valid && m_ins.rfm && !done);
    chk("wr_we", MEM_wr_bus[38], m_valid && m_ins.we);
    if (m_valid && done) begin
      fin = m_ins.rfm ? ref_load(m_ins.op, m_ins.alu[1:0], m_has ? m_data : rd) : m_ins.alu;
      chk("wb_bus", MEM_to_WB_bus, {m_ins.we, m_ins.dest, fin, m_ins.pc, m_ins.inst});
      chk("wr_result", MEM_wr_bus[37:1], {m_ins.dest, fin});
    end
  endtask

  task automatic tick();
    bit done, allow;
    @(posedge clk);
    done  = !m_wait || c_dok || m_has;
    allow = !m_valid || (done && c_wba);
    if (allow) begin
      if (c_ev) begin
        m_ins = unpack(c_bus); m_valid = 1; m_wait = m_ins.req; m_has = 0;
      end else begin
        m_valid = 0; m_wait = 0; m_has = 0;
      end
    end else if (m_wait && c_dok) begin
      m_has = 1; m_data = c_rd; m_wait = 0;
    end
  endtask

  task automatic step(input bit ev, input logic [106:0] bus, input bit dok,
                      input logic [31:0] rd, input bit wba);
    drive(ev, bus, dok, rd, wba);
    tick();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'd1, 1, 1, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80};
    vecs[1] = '{3'd4, 1, 1, 32'h0000_2002, 32'h8001_1234, 32'h0000_8001};
    vecs[2] = '{3'd2, 1, 1, 32'h0000_2002, 32'h8001_1234, 32'hFFFF_8001};
    vecs[3] = '{3'd0, 1, 1, 32'h0000_2000, 32'h8001_1234, 32'h8001_1234};
    vecs[4] = '{3'd3, 1, 1, 32'h0000_3001, 32'h0000_A500, 32'h0000_00A5};
    vecs[5] = '{3'd1, 1, 1, 32'h0000_4000, 32'h0000_007F, 32'h0000_007F};
    vecs[6] = '{3'd2, 1, 1, 32'h0000_5000, 32'h1234_FFFE, 32'hFFFF_FFFE};
    vecs[7] = '{3'd5, 1, 1, 32'h0000_6001, 32'hCAFE_BABE, 32'hCAFE_BABE};
    vecs[8] = '{3'd0, 0, 0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678};
    vecs[9] = '{3'd0, 0, 1, 32'h0000_00A0, 32'h5555_5555, 32'h0000_00A0};

    model_reset();
    resetn = 0;
    EXE_to_MEM_valid = 0; EXE_to_MEM_bus = '0; data_sram_data_ok = 0;
    data_sram_rdata = '0; WB_allow_in = 1;
    c_ev = 0; c_bus = '0; c_dok = 0; c_rd = '0; c_wba = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_allow_in", MEM_allow_in, 1'b1);
    chk("rst_wb_valid", MEM_to_WB_valid, 1'b0);
    chk("rst_wr_we", MEM_wr_bus[38], 1'b0);
    chk("rst_pending", MEM_wr_bus[0], 1'b0);
    @(negedge clk);
    resetn = 1;

    // Vector table: capture, then one cycle later respond (or not) with write-back open.
    for (int i = 0; i < 10; i++) begin
      step(1, mk_bus(vecs[i].alu, vecs[i].req, vecs[i].rfm, vecs[i].op, 1, 5'(i + 1),
                     32'h1000 + 32'(i * 4), 32'hA000 + 32'(i)), 0, '0, 1);
      drive(0, '0, vecs[i].req, vecs[i].rdata, 1);
      chk($sformatf("vec%0d_final", i), MEM_to_WB_bus[95:64], vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), MEM_to_WB_valid, 1'b1);
      tick();
    end

    // ld.b with the response two cycles after capture.
    step(1, mk_bus(32'h0000_0013, 1, 1, 3'd1, 1, 5'd3, 32'h200, 32'h300), 0, '0, 1);
    drive(0, '0, 0, '0, 1);
    chk("ldb_pending_c1", MEM_wr_bus[0], 1'b1);
    tick();
    drive(0, '0, 1, 32'h80FF_0000, 1);
    chk("ldb_final", MEM_to_WB_bus[95:64], 32'hFFFF_FF80);
    chk("ldb_pending_ok", MEM_wr_bus[0], 1'b0);
    tick();

    // Response under write-back back-pressure, with upstream and rdata changing meanwhile.
    step(1, mk_bus(32'h0000_0040, 1, 1, 3'd0, 1, 5'd7, 32'h400, 32'h500), 0, '0, 1);
    drive(1, mk_bus(32'h1, 0, 0, 3'd0, 1, 5'd8, 32'h404, 32'h504), 1, 32'hDEAD_BEEF, 0);
    chk("bp_allow_c0", MEM_allow_in, 1'b0);
    tick();
    for (int k = 1; k < 3; k++) begin
      drive(1, mk_bus(32'(k), 0, 0, 3'd0, 1, 5'd9, 32'h408, 32'h508), 0, $urandom, 0);
      chk($sformatf("bp_allow_c%0d", k), MEM_allow_in, 1'b0);
      chk($sformatf("bp_held_c%0d", k), MEM_to_WB_bus[95:64], 32'hDEAD_BEEF);
      tick();
    end
    drive(0, '0, 0, 32'h0BAD_F00D, 1);
    chk("bp_deliver", MEM_to_WB_bus[95:64], 32'hDEAD_BEEF);
    chk("bp_deliver_valid", MEM_to_WB_valid, 1'b1);
    tick();

    // Back-to-back loads, the second captured as the first leaves, then a spurious data_ok.
    step(1, mk_bus(32'h0000_0800, 1, 1, 3'd0, 1, 5'd10, 32'h600, 32'h700), 0, '0, 1);
    drive(1, mk_bus(32'h0000_0900, 1, 1, 3'd0, 1, 5'd11, 32'h604, 32'h704), 1, 32'h1111_1111, 1);
    chk("b2b_first", MEM_to_WB_bus[95:64], 32'h1111_1111);
    tick();
    drive(0, '0, 1, 32'h2222_2222, 1);
    chk("b2b_second", MEM_to_WB_bus[95:64], 32'h2222_2222);
    tick();
    step(0, '0, 1, 32'h3333_3333, 1);
    step(1, mk_bus(32'h0000_0C00, 1, 1, 3'd0, 1, 5'd12, 32'h608, 32'h708), 0, '0, 1);
    drive(0, '0, 0, '0, 1);
    chk("spurious_no_effect", MEM_wr_bus[0], 1'b1);
    tick();
    step(0, '0, 1, 32'h4444_4444, 1);

    // Reset while a response is outstanding; a stale data_ok afterwards must be ignored.
    step(1, mk_bus(32'h0000_0D00, 1, 1, 3'd2, 1, 5'd13, 32'h60C, 32'h70C), 0, '0, 1);
    step(0, '0, 0, '0, 1);
    @(negedge clk);
    #2;
    resetn = 0;
    EXE_to_MEM_valid = 0; data_sram_data_ok = 0;
    c_ev = 0; c_dok = 0;
    model_reset();
    #1;
    chk("mrst_wb_valid", MEM_to_WB_valid, 1'b0);
    chk("mrst_allow_in", MEM_allow_in, 1'b1);
    chk("mrst_pending", MEM_wr_bus[0], 1'b0);
    chk("mrst_wr_we", MEM_wr_bus[38], 1'b0);
    @(negedge clk);
    resetn = 1;
    drive(0, '0, 1, 32'hBAD0_BAD0, 1);
    chk("stale_wb_valid", MEM_to_WB_valid, 1'b0);
    tick();
    drive(0, '0, 0, '0, 1);
    chk("stale_after_valid", MEM_to_WB_valid, 1'b0);
    chk("stale_after_pending", MEM_wr_bus[0], 1'b0);
    tick();

    // Randomized traffic scored by the model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 4) != 0,
           mk_bus($urandom, $urandom % 2, $urandom % 2, 3'($urandom % 8), $urandom % 2,
                  5'($urandom), $urandom, $urandom),
           ($urandom % 3) == 0, $urandom, ($urandom % 4) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage; sits directly downstream of the execute stage and upstream of write-back.
- Latches the execute-stage bus and waits for the data-SRAM response when a load or store was issued.
- Aligns and sign/zero-extends load data, then selects the final write-back value.
- Drives the valid/allow-in handshake in both directions and a forwarding/stall bus back to decode.

Parameters:
- BUS_IN_W, 107, width of EXE_to_MEM_bus
- BUS_OUT_W, 102, width of MEM_to_WB_bus
- WR_BUS_W, 39, width of MEM_wr_bus

Ports:
- clk  in  1  clock (one clock domain)
- resetn  in  1  reset, asynchronous, active-low
- EXE_to_MEM_valid  in  1  upstream valid
- MEM_allow_in  out  1  stage can accept this cycle
- EXE_to_MEM_bus  in  107  {alu_result[31:0], req_issued, res_from_mem, ld_op[2:0], gr_we, dest[4:0], pc[31:0], inst[31:0]}
- data_sram_data_ok  in  1  one-cycle response pulse for the oldest outstanding request
- data_sram_rdata  in  32  read data, valid with data_ok
- MEM_to_WB_valid  out  1  downstream valid
- WB_allow_in  in  1  downstream can accept
- MEM_to_WB_bus  out  102  {gr_we, dest[4:0], final_result[31:0], pc[31:0], inst[31:0]}
- MEM_wr_bus  out  39  {gr_we&MEM_valid, dest[4:0], final_result[31:0], load_pending}

Behaviour:
- Reset (asynchronous, resetn=0):
  - MEM_valid=0, wait_resp=0, buf_valid=0, rdata_buf=0.
  - Outputs: MEM_to_WB_valid=0, MEM_allow_in=1, MEM_wr_bus[38]=0, MEM_wr_bus[0]=0.
  - The bus register holds a don't-care value, but the outputs derived from it are masked by MEM_valid.
- Handshake:
  - MEM_allow_in = ~MEM_valid | (ready_go & WB_allow_in).
  - MEM_to_WB_valid = MEM_valid & ready_go.
  - MEM_valid <= EXE_to_MEM_valid whenever MEM_allow_in=1.
  - The bus is captured only when EXE_to_MEM_valid & MEM_allow_in.
- Response tracking:
  - On capture, wait_resp <= req_issued.
  - When data_ok & wait_resp & ~(ready_go & WB_allow_in): store rdata into rdata_buf, set buf_valid=1, clear wait_resp.
  - buf_valid clears when the instruction leaves (ready_go & WB_allow_in).
  - ready_go = ~wait_resp | data_ok | buf_valid.
  - A store waits for data_ok exactly like a load.
  - data_ok while wait_resp=0 is ignored; no state change.
- Load data:
  - raw = buf_valid ? rdata_buf : data_sram_rdata.
  - Byte lane = alu_result[1:0]; halfword lane = alu_result[1].
  - ld_op encoding: 000 ld.w; 001 ld.b (sign-extend); 010 ld.h (sign-extend); 011 ld.bu (zero-extend); 100 ld.hu (zero-extend).
  - 101-111 are treated as ld.w.
  - Misaligned addresses are not checked; lanes are selected by the low bits only.
- final_result = res_from_mem ? load_data : alu_result.
- Latency:
  - No memory request: 1 cycle in the stage.
  - With a request: leaves in the same cycle as data_ok when WB_allow_in=1.
- Simultaneous events:
  - data_ok and new capture in the same cycle: the response belongs to the current instruction, which leaves.
  - The new instruction's wait_resp comes from its own req_issued.
  - WB back-pressure after data_ok: data is held in rdata_buf; the stage stays valid, upstream stalls.
- MEM_wr_bus[0] load_pending = MEM_valid & res_from_mem & ~ready_go. Decode stalls on a hazard while this is 1. final_result is meaningful only when load_pending=0.
- Reset mid-operation clears wait_resp and buf_valid. Any late data_ok is then ignored, because wait_resp=0.

Decomposition:
- Shared package:
  - ld_op encodings (LD_W, LD_B, LD_H, LD_BU, LD_HU).
  - Bus width constants: 107, 102, 39.
  - Field offsets for the EXE-to-MEM and MEM-to-WB buses.
- One natural combinational sub-module: load_align (ld_op, addr[1:0], raw[31:0] -> load_data[31:0]).

Test Plan:
- ALU op, req_issued=0, alu_result=0x1234_5678, WB_allow_in=1 -> MEM_to_WB_valid one cycle after capture; final_result=0x1234_5678; load_pending=0.
- ld.b, addr low=2'b11, data_ok with rdata=0x80FF_0000 two cycles after capture -> load_pending=1 until the data_ok cycle, then final_result=0xFFFF_FF80 the same cycle.
- ld.hu addr low=2'b10, rdata=0x8001_xxxx -> 0x0000_8001; ld.h same -> 0xFFFF_8001; ld.w -> rdata unchanged.
- data_ok while WB_allow_in=0 for 3 cycles, rdata=0xDEAD_BEEF, input changing afterwards -> MEM_allow_in=0 throughout; 0xDEAD_BEEF is delivered when WB_allow_in rises.
- Back-to-back loads: the second is captured in the same cycle the first leaves -> each gets its own data_ok, no data swap. A spurious data_ok with no request -> no effect.
- resetn asserted while wait_resp=1, released, then stale data_ok arrives -> MEM_valid=0, all outputs at reset values, stale response ignored.
